rs_enc_ilv: RTL and testbench

Parametrised CCSDS Reed-Solomon encoder with symbol interleaving depth, selectable correction capability and run-time shortening. It sits in the TM downlink path between the transfer-frame builder and the randomiser/ASM inserter. It accepts data symbols under a valid/ready handshake and emits the full interleaved codeblock: data first, then parity. Each parity delay element of the classic LFSR encoder is replaced by an I-deep delay line, so I codewords are encoded concurrently in one datapath.

---
 rtl/rs_enc_ilv.sv | 181 ++++++++++++++++++
 tb/tb_rs_enc_ilv.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rs_enc_ilv.sv
// CCSDS Reed-Solomon encoder with symbol interleaving. Each LFSR parity stage is an
// I-deep delay line, so I codewords are encoded in one shared datapath.

module rs_ilv_dline #(
    parameter int MM    = 8,
    parameter int DEPTH = 8,
    parameter int TW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          shift,
    input  logic [TW-1:0] tap,
    input  logic [MM-1:0] din,
    output logic [MM-1:0] tail
);
    logic [DEPTH-1:0][MM-1:0] line;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        line <= '0;
        else if (clr)   line <= '0;
        else if (shift) line <= {line[DEPTH-2:0], din};
    end

    // Tap I-1 holds the entry written I shifts ago, i.e. the same codeword.
    assign tail = line[tap];
endmodule

module rs_enc_ilv #(
    parameter int MM     = 8,
    parameter int TT     = 16,
    parameter int II_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clkEn,
    input  logic          start,
    input  logic [3:0]    depth,
    input  logic [7:0]    dataLen,
    input  logic [MM-1:0] dInp,
    input  logic          dInpValid,
    output logic          ready,
    output logic [MM-1:0] codeOut,
    output logic          codeValid,
    output logic          datNotParity,
    output logic          blockEnd
);
    localparam int NP   = 2 * TT;
    localparam int KMAX = 255 - NP;
    localparam int CW   = $clog2(255 * II_MAX + 1);
    localparam int TW   = $clog2(II_MAX);
    localparam logic [CW-1:0] ONE = CW'(1);

    // GF(2^8) multiply, field polynomial x^8+x^7+x^2+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h87 : 8'h00);
        end
        return p;
    endfunction

    // g(x) = prod (x + alpha^(11j)), j = 128-TT .. 127+TT; g[NP] is the monic 1.
    function automatic logic [NP:0][7:0] gen_poly();
        logic [NP:0][7:0] g;
        logic [7:0]       r, a11;
        g    = '0;
        g[0] = 8'h01;
        r    = 8'h01;
        a11  = 8'h01;
        for (int e = 0; e < (11 * (128 - TT)) % 255; e++) r = gf_mul(r, 8'h02);
        for (int e = 0; e < 11; e++) a11 = gf_mul(a11, 8'h02);
        for (int j = 0; j < NP; j++) begin
            for (int i = NP; i > 0; i--) g[i] = g[i-1] ^ gf_mul(g[i], r);
            g[0] = gf_mul(g[0], r);
            r    = gf_mul(r, a11);
        end
        return g;
    endfunction

    localparam logic [NP:0][7:0] GEN = gen_poly();

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;

    state_t                st;
    logic [CW-1:0]         cnt, tot, ptot;
    logic [TW-1:0]         tap;
    logic [NP-1:0][MM-1:0] tail;
    logic [MM-1:0]         fb;
    logic                  shift, clr;
    int                    di, dk;

    always_comb begin
        di = int'(depth);
        dk = int'(dataLen);
        if (di == 0)           di = 1;
        else if (di > II_MAX)  di = II_MAX;
        if (dk == 0 || dk > KMAX) dk = KMAX;
    end

    assign fb    = (st == S_DATA) ? (dInp ^ tail[NP-1]) : '0;
    assign shift = clkEn && ((st == S_DATA && dInpValid) || (st == S_PARITY && cnt != '0));
    assign clr   = clkEn && st == S_IDLE && start;

    for (genvar g = 0; g < NP; g++) begin : g_stage
        logic [MM-1:0] prev;
        if (g == 0) begin : g_first
            assign prev = '0;
        end else begin : g_rest
            assign prev = tail[g-1];
        end
        rs_ilv_dline #(.MM(MM), .DEPTH(II_MAX), .TW(TW)) u_dl (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .shift (shift),
            .tap   (tap),
            .din   (prev ^ gf_mul(fb, GEN[g])),
            .tail  (tail[g])
        );
    end

    // PARITY spends cnt==0 as the bubble cycle; symbols go out at cnt 1..2TT*I.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st           <= S_IDLE;
            cnt          <= '0;
            tot          <= '0;
            ptot         <= '0;
            tap          <= '0;
            ready        <= 1'b0;
            codeOut      <= '0;
            codeValid    <= 1'b0;
            datNotParity <= 1'b0;
            blockEnd     <= 1'b0;
        end else if (clkEn) begin
            codeValid    <= 1'b0;
            datNotParity <= 1'b0;
            blockEnd     <= 1'b0;
            case (st)
                S_IDLE: if (start) begin
                    st    <= S_DATA;
                    ready <= 1'b1;
                    cnt   <= '0;
                    tot   <= CW'(di * dk);
                    ptot  <= CW'(NP * di);
                    tap   <= TW'(di - 1);
                end
                S_DATA: if (dInpValid) begin
                    codeOut      <= dInp;
                    codeValid    <= 1'b1;
                    datNotParity <= 1'b1;
                    if (cnt == tot - ONE) begin
                        st    <= S_PARITY;
                        ready <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                S_PARITY: begin
                    if (cnt != '0) begin
                        codeOut   <= tail[NP-1];
                        codeValid <= 1'b1;
                    end
                    if (cnt == ptot) begin
                        blockEnd <= 1'b1;
                        st       <= S_IDLE;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_enc_ilv.sv
// Directed bench for rs_enc_ilv: stream shape, data passthrough and codeword syndromes
// (every codeword must vanish at all 2TT generator roots).

module tb_rs_enc_ilv;
    localparam int TT = 16, II_MAX = 8, NP = 2 * TT;

    logic       clk = 1'b0;
    logic       rst, clkEn, start, dInpValid;
    logic [3:0] depth;
    logic [7:0] dataLen, dInp;
    logic       ready, codeValid, datNotParity, blockEnd;
    logic [7:0] codeOut;

    int n_chk = 0, n_fail = 0;

    logic [7:0] dat    [0:2047];
    logic [7:0] datB   [0:222];
    logic [7:0] refpar [0:NP-1];
    logic [7:0] save_sym [$];
    logic [7:0] q_sym [$];
    logic       q_dnp [$];
    logic       q_end [$];
    logic [7:0] gexp [0:254];
    int         glog [0:255];

    rs_enc_ilv #(.MM(8), .TT(TT), .II_MAX(II_MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .clkEn        (clkEn),
        .start        (start),
        .depth        (depth),
        .dataLen      (dataLen),
        .dInp         (dInp),
        .dInpValid    (dInpValid),
        .ready        (ready),
        .codeOut      (codeOut),
        .codeValid    (codeValid),
        .datNotParity (datNotParity),
        .blockEnd     (blockEnd)
    );

    always #5 clk = ~clk;

    // A held output counts once: on the enabled cycle that retires it.
    always @(negedge clk)
        if (!rst && clkEn && codeValid) begin
            q_sym.push_back(codeOut);
            q_dnp.push_back(datNotParity);
            q_end.push_back(blockEnd);
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    task automatic start_block(input int dep, input int dlen, input string tag);
        q_sym.delete();
        q_dnp.delete();
        q_end.delete();
        chk({tag, "_idle_ready"}, ready, 0);
        clkEn = 1'b1; start = 1'b1; depth = 4'(dep); dataLen = 8'(dlen); dInpValid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; depth = 4'hf; dataLen = 8'd7;
        chk({tag, "_ready_after_start"}, ready, 1);
    endtask

    task automatic feed(input int total, input bit gaps, input bit inj, input string tag);
        int idx, cyc;
        bit ce, v, acc;
        idx = 0;
        cyc = 0;
        while (idx < total && cyc < 20000) begin
            ce = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            v  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            clkEn = ce; dInpValid = v; dInp = dat[idx];
            start = inj && idx == 7;
            if (inj && idx == 7) begin depth = 4'd0; dataLen = 8'd5; end
            acc = ce && v && ready;
            @(posedge clk); #1;
            if (acc && idx == 0 && !gaps) begin
                chk({tag, "_lat_sym"}, codeOut, dat[0]);
                chk({tag, "_lat_vld"}, {codeValid, datNotParity}, 2'b11);
            end
            if (acc) idx++;
            cyc++;
        end
        start = 1'b0;
        dInpValid = 1'b0;
        chk({tag, "_accepted"}, idx, total);
    endtask

    task automatic drain(input bit gaps, input string tag);
        int cyc;
        cyc = 0;
        dInpValid = 1'b0;
        while (!(q_end.size() > 0 && q_end[q_end.size()-1] === 1'b1) && cyc < 5000) begin
            clkEn = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        clkEn = 1'b1;
        chk({tag, "_end_seen"}, cyc < 5000, 1);
        chk({tag, "_vld_after_end"}, codeValid, 0);
    endtask

    task automatic check_block(input int I, input int k, input string tag);
        int bad_d, bad_e, bad_s, sz;
        logic [7:0] r, acc;
        sz = q_sym.size();
        chk({tag, "_len"}, sz, I * k + NP * I);
        bad_d = 0;
        bad_e = 0;
        for (int n = 0; n < sz; n++) begin
            if (q_dnp[n] !== (n < I * k)) bad_d++;
            else if (n < I * k && q_sym[n] !== dat[n]) bad_d++;
            if (q_end[n] !== (n == sz - 1)) bad_e++;
        end
        chk({tag, "_data"}, bad_d, 0);
        chk({tag, "_blockend"}, bad_e, 0);
        bad_s = 0;
        for (int c = 0; c < I; c++)
            for (int j = 128 - TT; j < 128 + TT; j++) begin
                r = gexp[(11 * j) % 255];
                acc = 8'h00;
                for (int n = c; n < sz; n += I) acc = gmul(acc, r) ^ q_sym[n];
                if (acc != 8'h00) bad_s++;
            end
        chk({tag, "_syndromes"}, bad_s, 0);
    endtask

    task automatic full_block(input int dep, input int dlen, input int I, input int k,
                              input bit gaps, input bit inj, input string tag);
        start_block(dep, dlen, tag);
        feed(I * k, gaps, inj, tag);
        drain(gaps, tag);
        check_block(I, k, tag);
    endtask

    task automatic fill_rand(input int total);
        for (int n = 0; n < total; n++) dat[n] = 8'($urandom);
    endtask

    initial begin
        logic [7:0] x;
        int bad;
        x = 8'h01;
        for (int e = 0; e < 255; e++) begin
            gexp[e] = x;
            glog[x] = e;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h87 : 8'h00);
        end

        rst = 1'b1; clkEn = 1'b0; start = 1'b0; depth = '0; dataLen = '0;
        dInp = '0; dInpValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_codeOut", codeOut, 0);
        chk("rst_codeValid", codeValid, 0);
        chk("rst_datNotParity", datNotParity, 0);
        chk("rst_blockEnd", blockEnd, 0);
        rst = 1'b0;
        clkEn = 1'b1;
        @(posedge clk); #1;

        // All-zero data: parity must be all zero.
        for (int n = 0; n < 223; n++) dat[n] = 8'h00;
        full_block(1, 223, 1, 223, 1'b0, 1'b0, "zero");
        bad = 0;
        for (int n = 223; n < q_sym.size(); n++) if (q_sym[n] != 8'h00) bad++;
        chk("zero_parity_nonzero", bad, 0);

        fill_rand(223);
        for (int n = 0; n < 223; n++) datB[n] = dat[n];
        full_block(1, 223, 1, 223, 1'b0, 1'b0, "rand_d1");
        for (int p = 0; p < NP; p++) refpar[p] = (q_sym.size() > 223 + p) ? q_sym[223 + p] : 8'h00;

        fill_rand(1115);
        full_block(5, 223, 5, 223, 1'b0, 1'b0, "d5");

        fill_rand(200);
        full_block(2, 100, 2, 100, 1'b0, 1'b0, "d2_short");

        fill_rand(1784);
        full_block(12, 0, 8, 223, 1'b0, 1'b0, "d12_clamp");

        // Same data with and without input gaps / clkEn bursts.
        fill_rand(150);
        full_block(3, 50, 3, 50, 1'b0, 1'b0, "nogap");
        save_sym = q_sym;
        full_block(3, 50, 3, 50, 1'b1, 1'b0, "gaps");
        bad = 0;
        for (int n = 0; n < save_sym.size() && n < q_sym.size(); n++)
            if (save_sym[n] !== q_sym[n]) bad++;
        chk("gaps_vs_nogap_diff", bad, 0);

        fill_rand(120);
        full_block(4, 30, 4, 30, 1'b0, 1'b1, "start_in_data");

        // Reset in the middle of PARITY, then rerun the earlier random block.
        for (int n = 0; n < 223; n++) dat[n] = datB[n];
        start_block(1, 223, "abort");
        feed(223, 1'b0, 1'b0, "abort");
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        #2;
        chk("abort_ready", ready, 0);
        chk("abort_codeOut", codeOut, 0);
        chk("abort_codeValid", codeValid, 0);
        chk("abort_datNotParity", datNotParity, 0);
        chk("abort_blockEnd", blockEnd, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        full_block(1, 223, 1, 223, 1'b0, 1'b0, "after_rst");
        bad = 0;
        for (int p = 0; p < NP; p++)
            if (q_sym.size() <= 223 + p || q_sym[223 + p] !== refpar[p]) bad++;
        chk("after_rst_parity_vs_ref", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
